coasia_modport: RTL and testbench
=================================

# coasia_modport

Registered eligibility evaluator on the slave side of the `coasia_if` bus, attached through the `coa_mp` modport view. Each clock it samples one application, described by:
- `mems`: member count.
- `lang_cer`: language-certificate level.
- `kore_sub`: Korean-subject flag.

It computes a score and returns a 2-bit `approval` verdict one cycle later. A saturating approval quota turns otherwise-approved applications into waitlisted ones once it is exhausted.

## Interface
Parameters:
- `PASS_SCORE`, default 8: minimum score for approval (5-bit compare).
- `QUOTA`, default 4: number of approvals granted before waitlisting; range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all logic on rising edge.
- `rst` input 1: synchronous active-high reset.
- `mems` input 3: member count; 0 means no application this cycle.
- `lang_cer` input 2: language-certificate level 0..3.
- `kore_sub` input 1: Korean-subject completed.
- `approval` output 2: verdict, registered.
  - 00 IDLE
  - 01 APPROVED
  - 10 REJECTED
  - 11 WAITLIST

## Operation
- **Application:** any sampled cycle with `mems` != 0. A cycle with `mems` == 0 is idle.
- **Score (5-bit unsigned, no overflow possible, max 16):** `mems` + 2×`lang_cer` + bonus.
  - bonus = 3 when `kore_sub`=1 and COASIA_KORE_BONUS_EN is defined.
  - bonus = 0 otherwise.
- **Verdict for an application:**
  - REJECTED if `lang_cer` == 0, regardless of score.
  - REJECTED if score < `PASS_SCORE`.
  - Otherwise eligible:
    - if `approve_cnt` < `QUOTA`: APPROVED, and `approve_cnt` increments.
    - else WAITLIST, and `approve_cnt` is unchanged.
- **Idle cycle:** `approval` <= IDLE; counters unchanged.
- **`approve_cnt`:** 8-bit internal, saturates at `QUOTA`. It is cleared only by `rst`; there is no window rollover.
- **Independence:** back-to-back applications are each evaluated independently. Identical consecutive inputs count as separate applications.
- **State machine:** two states.
  - OPEN (`approve_cnt` < `QUOTA`) -> FULL on the approval that makes `approve_cnt` == `QUOTA`.
  - FULL -> OPEN only via `rst`.

## Timing
- **Latency:** `approval` at edge N+1 reflects the inputs sampled at edge N. It holds for exactly one cycle and is then replaced by the next evaluation.
- **Bus timing:**
  - The master drives inputs 1 ns after a posedge.
  - The DUT samples them at the next posedge.
  - The master samples `approval` (#1step) at the following posedge.
- **Reset:**
  - While `rst`=1 at an edge: `approval` <= 00 and `approve_cnt` <= 0; inputs at that edge are discarded.
  - Reset has priority over a simultaneous application.
- **Reset release:** the first edge with `rst`=0 evaluates normally.
- **Quota boundary:** the application that brings `approve_cnt` to `QUOTA` is still APPROVED. The next eligible application is WAITLIST.
- **No X-propagation:** `approval` is always a defined 2-bit value after the first reset edge.

## Configuration
- **COASIA_KORE_BONUS_EN:**
  - Defined: `kore_sub`=1 adds 3 to the score.
  - Undefined: `kore_sub` is ignored; the port still exists and has no effect.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `mems`=7, `lang_cer`=3 -> `approval`=00 throughout; first post-reset edge evaluates.
- **Approve (macro on):** `mems`=3, `lang_cer`=2, `kore_sub`=1 -> score 10 -> `approval`=01 one cycle later.
- **Reject:**
  - `mems`=1, `lang_cer`=1, `kore_sub`=0 -> score 3 -> 10.
  - `mems`=7, `lang_cer`=0, `kore_sub`=1 -> 10 (zero-certificate rule).
- **Idle interleave:** `mems`=0 between applications -> 00 on those cycles; `approve_cnt` unchanged.
- **Quota:** 5 consecutive eligible applications with `QUOTA`=4 -> 01,01,01,01,11. Assert `rst`, then one eligible application -> 01.
- **Macro off:** `mems`=3, `lang_cer`=2, `kore_sub`=1 -> score 7 -> 10. With `mems`=4 -> score 8 -> 01.

Source files
------------

// File: rtl/coasia_modport.sv
// Slave-side (coa_mp view) eligibility evaluator: scores each application and registers a 2-bit verdict.
// Optional feature: define COASIA_KORE_BONUS_EN to add a 3-point Korean-subject bonus.
module coasia_modport #(
  parameter int PASS_SCORE = 8,
  parameter int QUOTA      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mems,
  input  logic [1:0] lang_cer,
  input  logic       kore_sub,
  output logic [1:0] approval
);

  localparam logic [4:0] PASS_5  = 5'(PASS_SCORE);
  localparam logic [7:0] QUOTA_8 = 8'(QUOTA);

  localparam logic [1:0] V_IDLE     = 2'b00;
  localparam logic [1:0] V_APPROVED = 2'b01;
  localparam logic [1:0] V_REJECTED = 2'b10;
  localparam logic [1:0] V_WAITLIST = 2'b11;

  typedef enum logic {OPEN = 1'b0, FULL = 1'b1} state_t;

  function automatic logic [4:0] calc_score(input logic [2:0] m, input logic [1:0] l,
                                            input logic k);
    logic [4:0] bonus;
`ifdef COASIA_KORE_BONUS_EN
    bonus = k ? 5'd3 : 5'd0;
`else
    bonus = 5'(k & 1'b0);
`endif
    return {2'b00, m} + {2'b00, l, 1'b0} + bonus;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic [7:0] lim);
    return (c >= lim) ? lim : c + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] score_p0;
  logic       app_p0, eligible_p0;
  logic [1:0] verdict_p0;

  assign score_p0    = calc_score(mems, lang_cer, kore_sub);
  assign app_p0      = (mems != 3'd0);
  assign eligible_p0 = app_p0 && (lang_cer != 2'd0) && (score_p0 >= PASS_5);

  // Stage p0 -> registered verdict; reset wins over a same-edge application
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OPEN;
      cnt_q    <= 8'd0;
      approval <= V_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      approval <= verdict_p0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (eligible_p0 && (state_q == OPEN)) begin
      cnt_d = sat_inc(cnt_q, QUOTA_8);
      if (cnt_d == QUOTA_8) state_d = FULL;
    end
  end

  always_comb begin
    verdict_p0 = V_IDLE;
    if (app_p0) begin
      if (!eligible_p0)         verdict_p0 = V_REJECTED;
      else if (state_q == OPEN) verdict_p0 = V_APPROVED;
      else                      verdict_p0 = V_WAITLIST;
    end
  end

endmodule

// File: tb/tb_coasia_modport.sv
// Directed bench for coasia_modport: reset, scoring, reject rules, idle cycles and the approval quota.
module tb_coasia_modport;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] mems = 3'd0;
  logic [1:0] lang_cer = 2'd0;
  logic       kore_sub = 1'b0;
  logic [1:0] approval;

  int tests = 0;
  int fails = 0;

  coasia_modport #(.PASS_SCORE(8), .QUOTA(4)) dut (
    .clk(clk), .rst(rst), .mems(mems), .lang_cer(lang_cer),
    .kore_sub(kore_sub), .approval(approval)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a posedge; the edge sampling them is followed by a #1 check window.
  task automatic drive(input logic [2:0] m, input logic [1:0] l, input logic k);
    mems = m; lang_cer = l; kore_sub = k;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'd0, 2'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(3'd7, 2'd3, 1'b0);
      tests++;
      if (approval !== 2'b00) begin
        fails++; $display("FAIL reset_hold[%0d]: approval=%b expected=00", i, approval);
      end
    end
    rst = 1'b0;
    drive(3'd7, 2'd3, 1'b0);
    tests++;
    if (approval !== 2'b01) begin
      fails++; $display("FAIL reset_release: approval=%b expected=01", approval);
    end
  endtask

  task automatic test_approve();
    logic [1:0] exp_kore;
`ifdef COASIA_KORE_BONUS_EN
    exp_kore = 2'b01;
`else
    exp_kore = 2'b10;
`endif
    do_reset();
    drive(3'd3, 2'd2, 1'b1);
    tests++;
    if (approval !== exp_kore) begin
      fails++; $display("FAIL approve_kore: approval=%b expected=%b", approval, exp_kore);
    end
    drive(3'd4, 2'd2, 1'b0);
    tests++;
    if (approval !== 2'b01) begin
      fails++; $display("FAIL approve_score8: approval=%b expected=01", approval);
    end
  endtask

  task automatic test_reject();
    logic [2:0] m_t [5] = '{3'd1, 3'd7, 3'd7, 3'd5, 3'd6};
    logic [1:0] l_t [5] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
    logic       k_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] e_t [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(m_t[i], l_t[i], k_t[i]);
      tests++;
      if (approval !== e_t[i]) begin
        fails++; $display("FAIL reject[%0d]: approval=%b expected=%b", i, approval, e_t[i]);
      end
    end
  endtask

  task automatic test_idle();
    logic [2:0] m_t [8] = '{3'd0, 3'd5, 3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd5};
    logic [1:0] l_t [8] = '{2'd3, 2'd2, 2'd0, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [1:0] e_t [8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(m_t[i], l_t[i], 1'b0);
      tests++;
      if (approval !== e_t[i]) begin
        fails++; $display("FAIL idle[%0d]: approval=%b expected=%b", i, approval, e_t[i]);
      end
    end
  endtask

  task automatic test_quota();
    logic [1:0] e_t [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(3'd4, 2'd2, 1'b0);
      tests++;
      if (approval !== e_t[i]) begin
        fails++; $display("FAIL quota[%0d]: approval=%b expected=%b", i, approval, e_t[i]);
      end
    end
    drive(3'd1, 2'd1, 1'b0);
    tests++;
    if (approval !== 2'b10) begin
      fails++; $display("FAIL quota_full_reject: approval=%b expected=10", approval);
    end
    rst = 1'b1;
    drive(3'd4, 2'd2, 1'b0);
    tests++;
    if (approval !== 2'b00) begin
      fails++; $display("FAIL quota_reset_priority: approval=%b expected=00", approval);
    end
    rst = 1'b0;
    drive(3'd4, 2'd2, 1'b0);
    tests++;
    if (approval !== 2'b01) begin
      fails++; $display("FAIL quota_after_reset: approval=%b expected=01", approval);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(3'd6, 2'd1, 1'b0);
    drive(3'd2, 2'd1, 1'b0);
    tests++;
    if (approval !== 2'b10) begin
      fails++; $display("FAIL b2b_reject_after_approve: approval=%b expected=10", approval);
    end
    drive(3'd0, 2'd0, 1'b0);
    tests++;
    if (approval !== 2'b00) begin
      fails++; $display("FAIL b2b_idle: approval=%b expected=00", approval);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_approve();
    test_reject();
    test_idle();
    test_quota();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
